// File: rtl/ahb_arb_pkg.sv
// Shared types and default widths for the AHB-lite multi-requester arbiter.
// Imported by the interface, the round-robin sub-block and the top.
package ahb_arb_pkg;

   localparam int DEF_NUM_REQ  = 2;
   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_WAIT_MAX = 15;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      ARB  = 2'b00,
      ADDR = 2'b01,
      DATA = 2'b10
   } state_t;

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Bundles requester handshake and AHB-lite bus signals between the arbiter and its peers.
// The master modport is the arbiter's view; slave is the environment's view.
interface ahb_master_arbiter_if #(
   parameter int NUM_REQ = ahb_arb_pkg::DEF_NUM_REQ,
   parameter int ADDR_W  = ahb_arb_pkg::DEF_ADDR_W,
   parameter int DATA_W  = ahb_arb_pkg::DEF_DATA_W
) ();

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        done;
   logic [NUM_REQ-1:0]        timeout;
   logic [DATA_W-1:0]         rdata;

   ahb_arb_pkg::htrans_t      htrans;
   logic                      hwrite;
   logic [ADDR_W-1:0]         haddr;
   logic [DATA_W-1:0]         hwdata;
   logic [DATA_W-1:0]         hrdata;
   logic                      hready;

   modport master (
      input  req, req_write, req_addr, req_wdata, hrdata, hready,
      output gnt, done, timeout, rdata, htrans, hwrite, haddr, hwdata
   );

   modport slave (
      output req, req_write, req_addr, req_wdata, hrdata, hready,
      input  gnt, done, timeout, rdata, htrans, hwrite, haddr, hwdata
   );

endinterface

// File: rtl/ahb_master_arbiter_rr.sv
// Round-robin request picker: search begins at index ptr and wraps around,
// producing a one-hot grant plus the binary index of the winner.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(ptr) + i) % NUM_REQ;
         if (!any && req[IDX_W'(cand)]) begin
            any                = 1'b1;
            grant[IDX_W'(cand)] = 1'b1;
            idx                = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-lite master port among NUM_REQ requesters with round-robin
// arbitration, single transfers only, and a data-phase wait-state timeout.
module ahb_master_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int WAIT_MAX = DEF_WAIT_MAX
) (
   input logic                  hclk,
   input logic                  hreset,
   ahb_master_arbiter_if.master bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   state_t              state;
   logic [NUM_REQ-1:0]  arb_grant;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_any;
   logic [IDX_W-1:0]    ptr;
   logic                lat_write;
   logic [DATA_W-1:0]   lat_wdata;
   logic [CNT_W-1:0]    wait_cnt;

   logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req   (bus.req),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // ptr holds the highest-priority index for the next arbitration, so the
   // requester after the last winner is searched first.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state       <= ARB;
         bus.htrans  <= IDLE;
         bus.hwrite  <= 1'b0;
         bus.haddr   <= '0;
         bus.hwdata  <= '0;
         bus.gnt     <= '0;
         bus.done    <= '0;
         bus.timeout <= '0;
         bus.rdata   <= '0;
         ptr         <= '0;
         wait_cnt    <= '0;
         lat_write   <= 1'b0;
         lat_wdata   <= '0;
      end else begin
         bus.done    <= '0;
         bus.timeout <= '0;
         case (state)
            ARB: begin
               if (arb_any) begin
                  bus.gnt    <= arb_grant;
                  bus.htrans <= NONSEQ;
                  bus.hwrite <= bus.req_write[arb_idx];
                  bus.haddr  <= addr_arr[arb_idx];
                  lat_write  <= bus.req_write[arb_idx];
                  lat_wdata  <= wdata_arr[arb_idx];
                  ptr        <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                  state      <= ADDR;
               end
            end
            ADDR: begin
               bus.htrans <= IDLE;
               bus.hwrite <= 1'b0;
               bus.haddr  <= '0;
               bus.hwdata <= lat_write ? lat_wdata : '0;
               wait_cnt   <= '0;
               state      <= DATA;
            end
            DATA: begin
               if (bus.hready) begin
                  bus.done   <= bus.gnt;
                  if (!lat_write) bus.rdata <= bus.hrdata;
                  bus.gnt    <= '0;
                  bus.hwdata <= '0;
                  state      <= ARB;
               end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
                  bus.timeout <= bus.gnt;
                  bus.gnt     <= '0;
                  bus.hwdata  <= '0;
                  state       <= ARB;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with a small AHB-lite memory slave;
// every expected value is written out by hand against the cycle timeline.
module tb_ahb_master_arbiter;

   logic hclk;
   logic hreset;

   int vectors_applied = 0;
   int miscompares     = 0;

   ahb_master_arbiter_if bus ();

   ahb_master_arbiter dut (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Simple slave: capture the address phase, write on the accepted data phase.
   logic [31:0] mem [256] = '{default: '0};
   logic [7:0]  d_addr;
   logic        d_write;
   logic        d_active;

   always @(posedge hclk) begin
      if (hreset) begin
         d_addr   <= '0;
         d_write  <= 1'b0;
         d_active <= 1'b0;
      end else begin
         if (d_active && bus.hready && d_write) mem[d_addr] <= bus.hwdata;
         if (bus.htrans == ahb_arb_pkg::NONSEQ) begin
            d_addr   <= bus.haddr;
            d_write  <= bus.hwrite;
            d_active <= 1'b1;
         end else if (bus.hready) begin
            d_active <= 1'b0;
         end
      end
   end

   assign bus.hrdata = mem[d_addr];

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      vectors_applied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] reqv, input logic [1:0] wr,
                                input logic [7:0] a0, input logic [7:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1);
      bus.req       = reqv;
      bus.req_write = wr;
      bus.req_addr  = {a1, a0};
      bus.req_wdata = {d1, d0};
   endtask

   task automatic tick();
      @(negedge hclk);
   endtask

   logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      hreset     = 1'b1;
      bus.hready = 1'b1;
      applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0);
      repeat (3) tick();

      checkOutput("rst_htrans",  64'(bus.htrans),  64'h0);
      checkOutput("rst_gnt",     64'(bus.gnt),     64'h0);
      checkOutput("rst_done",    64'(bus.done),    64'h0);
      checkOutput("rst_timeout", 64'(bus.timeout), 64'h0);
      checkOutput("rst_rdata",   64'(bus.rdata),   64'h0);
      checkOutput("rst_haddr",   64'({bus.hwrite, bus.haddr}), 64'h0);
      checkOutput("rst_hwdata",  64'(bus.hwdata),  64'h0);
      hreset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         tick();
         checkOutput("idle_bus", 64'({bus.htrans, bus.gnt}), 64'h0);
      end

      // Write from requester 0 with one wait state
      applyStimulus(2'b01, 2'b01, 8'h0d, 8'h00, 32'h5a5a_5a5a, 32'h0);
      bus.hready = 1'b0;
      tick();
      checkOutput("wr_htrans", 64'(bus.htrans), 64'h2);
      checkOutput("wr_haddr",  64'(bus.haddr),  64'h0d);
      checkOutput("wr_hwrite", 64'(bus.hwrite), 64'h1);
      checkOutput("wr_gnt",    64'(bus.gnt),    64'h1);
      tick();
      checkOutput("wr_hwdata", 64'(bus.hwdata), 64'h5a5a_5a5a);
      checkOutput("wr_dphase", 64'({bus.htrans, bus.gnt}), 64'h1);
      bus.hready = 1'b1;
      tick();
      checkOutput("wr_done",    64'(bus.done),    64'h1);
      checkOutput("wr_timeout", 64'(bus.timeout), 64'h0);
      checkOutput("wr_gnt_rel", 64'(bus.gnt),     64'h0);
      checkOutput("wr_mem",     64'(mem[8'h0d]),  64'h5a5a_5a5a);
      bus.req = 2'b00;
      tick();
      checkOutput("wr_done_pulse", 64'(bus.done), 64'h0);

      // Read back through requester 1
      applyStimulus(2'b10, 2'b00, 8'h00, 8'h0d, 32'h0, 32'h0);
      tick();
      checkOutput("rd_gnt",    64'(bus.gnt),    64'h2);
      checkOutput("rd_hwrite", 64'(bus.hwrite), 64'h0);
      checkOutput("rd_haddr",  64'(bus.haddr),  64'h0d);
      tick();
      checkOutput("rd_hwdata", 64'(bus.hwdata), 64'h0);
      tick();
      checkOutput("rd_done",  64'(bus.done),  64'h2);
      checkOutput("rd_rdata", 64'(bus.rdata), 64'h5a5a_5a5a);
      bus.req = 2'b00;
      tick();

      // Both requesters held high: grants must alternate
      applyStimulus(2'b11, 2'b11, 8'h21, 8'h22, 32'h1111_0000, 32'h2222_0001);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput("rr_gnt", 64'(bus.gnt), 64'(rr_exp[k]));
         tick();
         tick();
         checkOutput("rr_done", 64'({bus.timeout, bus.done}), 64'(rr_exp[k]));
      end
      bus.req = 2'b00;
      checkOutput("rr_mem0", 64'(mem[8'h21]), 64'h1111_0000);
      checkOutput("rr_mem1", 64'(mem[8'h22]), 64'h2222_0001);
      checkOutput("rr_rdata_kept", 64'(bus.rdata), 64'h5a5a_5a5a);
      tick();

      // Slave never ready: timeout 16 cycles after data phase entry
      applyStimulus(2'b01, 2'b00, 8'h20, 8'h00, 32'h0, 32'h0);
      bus.hready = 1'b0;
      tick();
      checkOutput("to_gnt", 64'(bus.gnt), 64'h1);
      for (int k = 0; k < 16; k++) begin
         tick();
         checkOutput("to_wait", 64'({bus.timeout, bus.done}), 64'h0);
      end
      tick();
      checkOutput("to_pulse", 64'(bus.timeout), 64'h1);
      checkOutput("to_nodone", 64'(bus.done),   64'h0);
      checkOutput("to_gnt_rel", 64'(bus.gnt),   64'h0);
      bus.req = 2'b00;
      tick();
      checkOutput("to_pulse_end", 64'(bus.timeout), 64'h0);
      bus.hready = 1'b1;
      applyStimulus(2'b10, 2'b10, 8'h00, 8'h30, 32'h0, 32'h1234_5678);
      tick();
      checkOutput("post_to_gnt", 64'(bus.gnt), 64'h2);
      tick();
      tick();
      checkOutput("post_to_done", 64'(bus.done), 64'h2);
      checkOutput("post_to_mem", 64'(mem[8'h30]), 64'h1234_5678);
      bus.req = 2'b00;
      tick();

      // Reset in the middle of a data phase
      applyStimulus(2'b01, 2'b01, 8'h40, 8'h00, 32'hdead_beef, 32'h0);
      bus.hready = 1'b0;
      tick();
      tick();
      checkOutput("mid_hwdata", 64'(bus.hwdata), 64'hdead_beef);
      hreset  = 1'b1;
      bus.req = 2'b00;
      tick();
      checkOutput("mr_bus",    64'({bus.htrans, bus.hwrite, bus.haddr}), 64'h0);
      checkOutput("mr_hwdata", 64'(bus.hwdata), 64'h0);
      checkOutput("mr_pulses", 64'({bus.gnt, bus.timeout, bus.done}), 64'h0);
      checkOutput("mr_rdata",  64'(bus.rdata),  64'h0);
      hreset     = 1'b0;
      bus.hready = 1'b1;
      applyStimulus(2'b11, 2'b00, 8'h0d, 8'h0d, 32'h0, 32'h0);
      tick();
      checkOutput("mr_ptr_gnt", 64'(bus.gnt), 64'h1);
      tick();
      tick();
      checkOutput("mr_done",  64'({bus.timeout, bus.done}), 64'h1);
      checkOutput("mr_rdata2", 64'(bus.rdata), 64'h5a5a_5a5a);
      checkOutput("mr_mem",   64'(mem[8'h40]), 64'h0);
      bus.req = 2'b10;
      tick();
      checkOutput("mr_gnt1", 64'(bus.gnt), 64'h2);
      bus.req = 2'b00;
      tick();
      tick();
      checkOutput("mr_done1", 64'(bus.done), 64'h2);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
